// File: rtl/sa_skew_feeder.sv
// Operand feeder for the N x N systolic PE array.
// Skews A columns / B rows per lane and sequences each job.
module sa_skew_feeder #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int KW    = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [KW-1:0]      k_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N*WIDTH-1:0] a_vec_in,
    input  logic [N*WIDTH-1:0] b_vec_in,
    output logic [N*WIDTH-1:0] a_edge_out,
    output logic [N*WIDTH-1:0] b_edge_out,
    output logic               pe_en,
    output logic               busy,
    output logic               done
);

    localparam int FW = $clog2(2 * N);
    localparam logic [FW-1:0] FLUSH_LAST = FW'(2 * N - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH,
        DONE
    } state_t;

    state_t        state;
    logic [KW-1:0] k_q;
    logic [KW-1:0] cnt;
    logic [KW-1:0] cnt_nx;
    logic [FW-1:0] fcnt;
    logic          take;
    logic          clear;

    assign take   = in_valid && in_ready;
    assign clear  = (state == IDLE);
    assign cnt_nx = cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            k_q      <= '0;
            cnt      <= '0;
            fcnt     <= '0;
            in_ready <= 1'b0;
            pe_en    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && (k_len != '0)) begin
                        state    <= LOAD;
                        k_q      <= k_len;
                        cnt      <= '0;
                        in_ready <= 1'b1;
                        pe_en    <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (take) begin
                        cnt <= cnt_nx;
                        if (cnt_nx == k_q) begin
                            state    <= FLUSH;
                            fcnt     <= '0;
                            in_ready <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    // Drain until the last beat has crossed the whole array
                    if (fcnt == FLUSH_LAST) begin
                        state <= DONE;
                        pe_en <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [WIDTH-1:0]       a_lane;
        logic [WIDTH-1:0]       b_lane;
        logic [(i+1)*WIDTH-1:0] a_sr;
        logic [(i+1)*WIDTH-1:0] b_sr;
        logic [(i+1)*WIDTH-1:0] a_nx;
        logic [(i+1)*WIDTH-1:0] b_nx;
        logic [WIDTH-1:0]       a_q;
        logic [WIDTH-1:0]       b_q;

        // Idle lanes inject zero bubbles
        assign a_lane = take ? a_vec_in[i*WIDTH +: WIDTH] : '0;
        assign b_lane = take ? b_vec_in[i*WIDTH +: WIDTH] : '0;

        if (i == 0) begin : g_head
            assign a_nx = a_lane;
            assign b_nx = b_lane;
        end else begin : g_tail
            assign a_nx = {a_sr[i*WIDTH-1:0], a_lane};
            assign b_nx = {b_sr[i*WIDTH-1:0], b_lane};
        end

        always_ff @(posedge clk) begin
            if (!rst_n || clear) begin
                a_sr <= '0;
                b_sr <= '0;
                a_q  <= '0;
                b_q  <= '0;
            end else begin
                a_sr <= a_nx;
                b_sr <= b_nx;
                a_q  <= a_sr[i*WIDTH +: WIDTH];
                b_q  <= b_sr[i*WIDTH +: WIDTH];
            end
        end

        assign a_edge_out[i*WIDTH +: WIDTH] = a_q;
        assign b_edge_out[i*WIDTH +: WIDTH] = b_q;
    end

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder with edge scoreboard
// and a behavioural 4x4 PE array for end-to-end checks.
module tb_sa_skew_feeder;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int KW = 8;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] a_vec_in;
    logic [NW-1:0] b_vec_in;
    logic [NW-1:0] a_edge_out;
    logic [NW-1:0] b_edge_out;
    logic          pe_en;
    logic          busy;
    logic          done;

    sa_skew_feeder #(.N(N), .WIDTH(W), .KW(KW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec_in  (a_vec_in),
        .b_vec_in  (b_vec_in),
        .a_edge_out(a_edge_out),
        .b_edge_out(b_edge_out),
        .pe_en     (pe_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int e      = 0;
    int left   = 0;

    logic [NW-1:0] ea [int];
    logic [NW-1:0] eb [int];
    int            dq [$];

    // Behavioural PE array: a flows right, b flows down
    logic pe_clr = 1'b0;
    int   ar  [N][N];
    int   br  [N][N];
    int   acc [N][N];
    int   ain [N][N];
    int   bin [N][N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j == 0) ain[i][j] = int'($signed(a_edge_out[i*W +: W]));
                else        ain[i][j] = ar[i][j-1];
                if (i == 0) bin[i][j] = int'($signed(b_edge_out[j*W +: W]));
                else        bin[i][j] = br[i-1][j];
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (pe_clr) begin
                    acc[i][j] <= 0;
                    ar[i][j]  <= 0;
                    br[i][j]  <= 0;
                end else if (pe_en) begin
                    acc[i][j] <= acc[i][j] + ain[i][j] * bin[i][j];
                    ar[i][j]  <= ain[i][j];
                    br[i][j]  <= bin[i][j];
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_beat(input int t, input logic [NW-1:0] a,
                             input logic [NW-1:0] b);
        logic [NW-1:0] ta, tb;
        for (int i = 0; i < N; i++) begin
            ta = ea.exists(t + 1 + i) ? ea[t + 1 + i] : '0;
            tb = eb.exists(t + 1 + i) ? eb[t + 1 + i] : '0;
            ta[i*W +: W] = a[i*W +: W];
            tb[i*W +: W] = b[i*W +: W];
            ea[t + 1 + i] = ta;
            eb[t + 1 + i] = tb;
        end
    endtask

    task automatic cyc_step();
        logic [NW-1:0] xa, xb;
        logic xd;
        @(posedge clk);
        e++;
        @(negedge clk);
        xa = ea.exists(e) ? ea[e] : '0;
        xb = eb.exists(e) ? eb[e] : '0;
        chk("a_edge", a_edge_out, xa);
        chk("b_edge", b_edge_out, xb);
        xd = (dq.size() > 0) && (dq[0] == e);
        if (xd) void'(dq.pop_front());
        chk("done", done, xd);
        if (xd) begin
            chk("done_pe_en", pe_en, 1'b0);
            chk("done_busy", busy, 1'b0);
        end
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) cyc_step();
    endtask

    task automatic start_job(input int k);
        left  = k;
        start = 1'b1;
        k_len = KW'(k);
        cyc_step();
        start = 1'b0;
        k_len = '0;
        chk("start_busy", busy, 1'b1);
        chk("start_pe_en", pe_en, 1'b1);
    endtask

    task automatic beat(input logic [NW-1:0] a, input logic [NW-1:0] b);
        chk("in_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        a_vec_in = a;
        b_vec_in = b;
        push_beat(e + 1, a, b);
        left--;
        if (left == 0) dq.push_back(e + 1 + 2 * N);
        cyc_step();
        in_valid = 1'b0;
        a_vec_in = '0;
        b_vec_in = '0;
    endtask

    function automatic logic [NW-1:0] pack(input int v0, input int v1,
                                           input int v2, input int v3);
        return {W'(v3), W'(v2), W'(v1), W'(v0)};
    endfunction

    task automatic e2e(input int sgn, input string tag);
        logic [NW-1:0] a, b;
        pe_clr = 1'b1;
        cyc_step();
        pe_clr = 1'b0;
        start_job(N);
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                a[i*W +: W] = (i == k) ? W'(sgn) : '0;
                b[i*W +: W] = W'(N * k + i + 1);
            end
            beat(a, b);
        end
        steps(2 * N + 2);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                chk(tag, 64'(acc[i][j]), 64'(sgn * (N * i + j + 1)));
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b1;
        k_len    = 8'd3;
        in_valid = 1'b0;
        a_vec_in = '0;
        b_vec_in = '0;

        for (int c = 0; c < 3; c++) begin
            cyc_step();
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_pe_en", pe_en, 1'b0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        steps(3);
        chk("post_rst_busy", busy, 1'b0);

        // single beat skew timing
        start_job(1);
        beat(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_busy", busy, 1'b1);
        chk("flush_pe_en", pe_en, 1'b1);
        steps(10);
        chk("job1_busy", busy, 1'b0);

        // bubble in the middle of a job
        start_job(3);
        beat(pack(8'h11, 8'h12, 8'h13, 8'h14), pack(8'h21, 8'h22, 8'h23, 8'h24));
        cyc_step();
        beat(pack(8'h31, 8'h32, 8'h33, 8'h34), pack(8'h41, 8'h42, 8'h43, 8'h44));
        beat(pack(8'h80, 8'hff, 8'h7f, 8'h01), pack(8'hfe, 8'h00, 8'h81, 8'h55));
        steps(11);

        // zero-length start is ignored
        start = 1'b1;
        k_len = '0;
        cyc_step();
        start = 1'b0;
        chk("k0_busy", busy, 1'b0);
        chk("k0_in_ready", in_ready, 1'b0);
        steps(2);
        chk("k0_busy_later", busy, 1'b0);

        // starts during LOAD and FLUSH are ignored
        start_job(2);
        beat(pack(9, 9, 9, 9), pack(3, 3, 3, 3));
        start = 1'b1;
        k_len = 8'd5;
        cyc_step();
        start = 1'b0;
        beat(pack(1, 1, 1, 1), pack(2, 2, 2, 2));
        steps(2);
        start = 1'b1;
        k_len = 8'd3;
        cyc_step();
        start = 1'b0;
        steps(9);
        chk("ign_busy", busy, 1'b0);
        chk("ign_done_seen", 64'(dq.size()), 64'd0);

        // reset in the middle of a job
        start_job(5);
        beat(pack(5, 6, 7, 8), pack(1, 2, 3, 4));
        beat(pack(4, 3, 2, 1), pack(8, 7, 6, 5));
        rst_n = 1'b0;
        ea.delete();
        eb.delete();
        dq.delete();
        left = 0;
        cyc_step();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b0);
        chk("mid_rst_pe_en", pe_en, 1'b0);
        rst_n = 1'b1;
        steps(4);
        start_job(2);
        beat(pack(10, 20, 30, 40), pack(50, 60, 70, 80));
        beat(pack(1, 2, 3, 4), pack(5, 6, 7, 8));
        steps(10);
        chk("mid_rst_done_seen", 64'(dq.size()), 64'd0);

        // identity and negated identity through the array model
        e2e(1, "acc_pos");
        e2e(-1, "acc_neg");
        chk("final_done_seen", 64'(dq.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
